// File: rtl/fetch_seq_if.sv
// Fetch front-end bundle: ROM/control/branch inputs in, PC, pipeline register and diagnostics out.
// No handshake: stall is the only backpressure and it freezes the whole fetch state.
interface fetch_seq_if #(
  parameter int D  = 12,
  parameter int IW = 9,
  parameter int CW = 16
);
  logic [IW-1:0] instr_in;
  logic          stall;
  logic          branch_en;
  logic          br_flag;
  logic          rel_mode;
  logic [D-1:0]  target;
  logic [D-1:0]  prog_ctr;
  logic [IW-1:0] instr_out;
  logic [D-1:0]  instr_pc;
  logic          instr_valid;
  logic          done;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] stall_cnt;

  modport master (
    output instr_in, stall, branch_en, br_flag, rel_mode, target,
    input  prog_ctr, instr_out, instr_pc, instr_valid, done, run_cnt, stall_cnt
  );

  modport slave (
    input  instr_in, stall, branch_en, br_flag, rel_mode, target,
    output prog_ctr, instr_out, instr_pc, instr_valid, done, run_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_seq.sv
// PC owner plus one-deep fetch->execute register with one-bubble branch squash and sticky halt.
// First valid instr 2 cycles after reset, taken branch to target 2 cycles; stall holds all fetch state.
module fetch_seq #(
  parameter int D          = 12,
  parameter int IW         = 9,
  parameter int START_ADDR = 0,
  parameter int DONE_ADDR  = 128,
  parameter int CW         = 16
) (
  input  logic       clk,
  input  logic       reset,
  fetch_seq_if.slave bus
);

  localparam logic [D-1:0] START_PC = D'(START_ADDR);
  localparam logic [D-1:0] DONE_PC  = D'(DONE_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [D-1:0]  ipc_q, ipc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          vld_q, vld_d;
  logic          done_q, done_d;
  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] stl_q, stl_d;
  logic          taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      ipc_q   <= '0;
      instr_q <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      run_q   <= '0;
      stl_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      run_q   <= run_d;
      stl_q   <= stl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    done_d  = done_q;
    run_d   = run_q;
    stl_d   = stl_q;
    // Only a real, unstalled instruction can redirect; the squashed slot never can.
    taken   = (state_q == RUN) & vld_q & bus.branch_en & bus.br_flag & ~bus.stall;

    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (bus.stall) stl_d = (stl_q == '1) ? stl_q : stl_q + CW'(1);
        else           run_d = (run_q == '1) ? run_q : run_q + CW'(1);

        // Halt check ignores stall but loses to a branch resolving this cycle.
        if (pc_q == DONE_PC && !taken) begin
          state_d = HALT;
          done_d  = 1'b1;
          vld_d   = 1'b0;
        end else if (!bus.stall) begin
          ipc_d = pc_q;
          if (taken) begin
            instr_d = '0;
            vld_d   = 1'b0;
            pc_d    = bus.rel_mode ? ipc_q + bus.target : bus.target;
          end else begin
            instr_d = bus.instr_in;
            vld_d   = 1'b1;
            pc_d    = pc_q + D'(1);
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.prog_ctr    = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = vld_q;
  assign bus.done        = done_q;
  assign bus.run_cnt     = run_q;
  assign bus.stall_cnt   = stl_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Table-driven bench for fetch_seq: per-cycle input/expected records pushed to a scoreboard queue.
// ROM model returns the low 9 bits of the fetch address, so instr_out must track instr_pc.
module tb_fetch_seq;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fetch_seq_if #(.D(12), .IW(9), .CW(16)) bus ();

  fetch_seq #(
    .D(12), .IW(9), .START_ADDR(0), .DONE_ADDR(128), .CW(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instr_in = bus.prog_ctr[8:0];

  typedef struct {
    logic        rst, stall, ben, bfl, rel;
    logic [11:0] tgt;
    logic [11:0] pc, ipc;
    logic        vld, done, chk_cnt;
    logic [15:0] run, stl;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(logic rst, logic stall, logic ben, logic bfl, logic rel,
                              logic [11:0] tgt, logic [11:0] pc, logic [11:0] ipc,
                              logic vld, logic done);
    vec_t v;
    v.rst = rst; v.stall = stall; v.ben = ben; v.bfl = bfl; v.rel = rel; v.tgt = tgt;
    v.pc = pc; v.ipc = ipc; v.vld = vld; v.done = done;
    v.chk_cnt = 1'b0; v.run = '0; v.stl = '0;
    return v;
  endfunction

  task automatic add_cnt(input int run, input int stl);
    vec_t v;
    v = tbl.pop_back();
    v.chk_cnt = 1'b1;
    v.run = 16'(run);
    v.stl = 16'(stl);
    tbl.push_back(v);
  endtask

  task automatic add_rst();
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_cnt(0, 0);
  endtask

  task automatic add_idle();
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Straight-line fetches starting with prog_ctr == start.
  task automatic add_run(input int start, input int n);
    for (int k = 0; k < n; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 12'(start + k + 1), 12'(start + k), 1, 0));
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h, expected %0h", nm, row, act, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.branch_en = 1'b0; bus.br_flag = 1'b0;
    bus.rel_mode = 1'b0; bus.target = '0;

    // Straight-line, absolute branch at 5 -> 40, branch_en without br_flag.
    add_rst(); add_rst(); add_idle(); add_run(0, 6);
    tbl.push_back(mk(0, 0, 1, 1, 0, 40, 40, 6, 0, 0));
    add_run(40, 2);
    tbl.push_back(mk(0, 0, 1, 0, 0, 12'd99, 43, 42, 1, 0));
    add_cnt(10, 0);

    // Stall for 3 cycles with a pending branch at instr_pc 9.
    add_rst(); add_idle(); add_run(0, 10);
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 1, 1, 1, 0, 50, 10, 9, 1, 0));
    add_cnt(10, 3);
    tbl.push_back(mk(0, 0, 1, 1, 0, 50, 50, 10, 0, 0));
    add_run(50, 1);
    add_cnt(12, 3);

    // Relative branch at 20 with offset -4.
    add_rst(); add_idle(); add_run(0, 21);
    tbl.push_back(mk(0, 0, 1, 1, 1, 12'hFFC, 16, 21, 0, 0));
    add_run(16, 1);

    // Relative branch at 2 with offset -4 wraps to 0xFFE, then PC wraps through 0.
    add_rst(); add_idle(); add_run(0, 3);
    tbl.push_back(mk(0, 0, 1, 1, 1, 12'hFFC, 12'hFFE, 3, 0, 0));
    add_run(12'hFFE, 3);

    // Halt at 128 (reached under stall), then inert under stall/branch, then reset.
    add_rst(); add_idle(); add_run(0, 128);
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 128, 127, 0, 1));
    add_cnt(128, 1);
    tbl.push_back(mk(0, 1, 1, 1, 0, 7, 128, 127, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 7, 128, 127, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 7, 128, 127, 0, 1));
    add_cnt(128, 1);
    add_rst();

    // Hand-written: branch taken while prog_ctr == 128, then branch to 128.
    add_idle(); add_run(0, 128);
    tbl.push_back(mk(0, 0, 1, 1, 0, 200, 200, 128, 0, 0));
    add_run(200, 1);
    tbl.push_back(mk(0, 0, 1, 1, 0, 128, 128, 201, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 128, 201, 0, 1));

    // Hand-written: reset right after a taken branch leaves no stale bubble.
    add_rst(); add_idle(); add_run(0, 6);
    tbl.push_back(mk(0, 0, 1, 1, 0, 40, 40, 6, 0, 0));
    tbl.push_back(mk(1, 0, 1, 1, 0, 40, 0, 0, 0, 0));
    add_cnt(0, 0);
    add_idle(); add_run(0, 2);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v, e;
      v = tbl[i];
      reset         = v.rst;
      bus.stall     = v.stall;
      bus.branch_en = v.ben;
      bus.br_flag   = v.bfl;
      bus.rel_mode  = v.rel;
      bus.target    = v.tgt;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("prog_ctr", i, 32'(bus.prog_ctr), 32'(e.pc));
      chk("instr_pc", i, 32'(bus.instr_pc), 32'(e.ipc));
      chk("instr_valid", i, 32'(bus.instr_valid), 32'(e.vld));
      chk("done", i, 32'(bus.done), 32'(e.done));
      if (e.vld)       chk("instr_out", i, 32'(bus.instr_out), 32'(e.ipc[8:0]));
      else if (!e.done) chk("instr_out_zero", i, 32'(bus.instr_out), 32'd0);
      if (e.chk_cnt) begin
        chk("run_cnt", i, 32'(bus.run_cnt), 32'(e.run));
        chk("stall_cnt", i, 32'(bus.stall_cnt), 32'(e.stl));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
